// File: rtl/bin_to_bcd_seq_if.sv
// Bundle between the binary producer and the sequential BCD converter.
// The producer (master) drives bin_i/bin_valid_i. The converter (slave)
// returns the registered result, the blanking mask and status.
//
// Strobe semantics: there is no ready. bin_i is taken on every clock edge
// where bin_valid_i is high. While busy, a new value waits in a one-deep slot
// and the latest value wins. bcd_valid_o is a one-cycle pulse in the cycle
// that bcd_o, digit_en_o and overflow_o change.
interface bin_to_bcd_seq_if #(
   parameter int N = 20,
   parameter int D = 6
);
   logic [N-1:0]   bin_i;
   logic           bin_valid_i;
   logic           busy_o;
   logic [4*D-1:0] bcd_o;
   logic [D-1:0]   digit_en_o;
   logic           overflow_o;
   logic           bcd_valid_o;

   modport master (
      output bin_i, bin_valid_i,
      input  busy_o, bcd_o, digit_en_o, overflow_o, bcd_valid_o
   );

   modport slave (
      input  bin_i, bin_valid_i,
      output busy_o, bcd_o, digit_en_o, overflow_o, bcd_valid_o
   );
endinterface

// File: rtl/bin_to_bcd_seq.sv
// Sequential binary to BCD converter. It uses shift-and-add-3 and converts
// one bit per clock. It also builds a leading-zero blanking mask and flags
// values that are too large to show in D digits.
module bin_to_bcd_seq #(
   parameter int N = 20,
   parameter int D = 6
) (
   input logic            clk,
   input logic            reset,
   bin_to_bcd_seq_if.slave bus
);
   localparam int W  = 4*D + N;
   localparam int CW = (N > 1) ? $clog2(N) : 1;

   function automatic logic [63:0] pow10(input int d);
      logic [63:0] p;
      p = 64'd1;
      for (int i = 0; i < d; i++) p = p * 64'd10;
      return p;
   endfunction

   localparam logic [63:0] LIMIT = pow10(D);

   typedef enum logic {IDLE = 1'b0, SHIFT = 1'b1} state_t;

   state_t         state_q, state_d;
   logic [W-1:0]   sreg_q;
   logic [CW-1:0]  cnt_q;
   logic           ovf_q;
   logic           pend_q;
   logic [N-1:0]   pend_val_q;
   logic [4*D-1:0] bcd_q;
   logic [D-1:0]   en_q;
   logic           ovf_out_q;
   logic           valid_q;

   logic [W-1:0]   adj;
   logic [W-1:0]   shifted;
   logic [4*D-1:0] digits;
   logic [D-1:0]   en_calc;
   logic           any_nz;
   logic           last;
   logic           load;
   logic [N-1:0]   load_val;
   logic           load_ovf;
   logic           busy;

   // Add 3 to each digit that is 5 or more, then shift left by one bit
   always_comb begin
      adj = sreg_q;
      for (int k = 0; k < D; k++) begin
         if (sreg_q[N+4*k +: 4] >= 4'd5) adj[N+4*k +: 4] = sreg_q[N+4*k +: 4] + 4'd3;
      end
      shifted = {adj[W-2:0], 1'b0};
      digits  = shifted[W-1:N];
   end

   // Blanking mask: show a digit if it or any more significant digit is nonzero
   always_comb begin
      any_nz  = 1'b0;
      en_calc = '0;
      for (int k = D - 1; k >= 0; k--) begin
         any_nz     = any_nz | (digits[4*k +: 4] != 4'd0);
         en_calc[k] = any_nz | (k == 0);
      end
   end

   // Control: final-bit detect and load selection (a fresh strobe beats the pending slot)
   always_comb begin
      last     = (state_q == SHIFT) && (cnt_q == CW'(N - 1));
      load     = ((state_q == IDLE) && bus.bin_valid_i) ||
                 (last && (bus.bin_valid_i || pend_q));
      load_val = bus.bin_valid_i ? bus.bin_i : pend_val_q;
      load_ovf = (64'(load_val) >= LIMIT);
   end

   // FSM state register
   always_ff @(posedge clk) begin
      if (reset) state_q <= IDLE;
      else       state_q <= state_d;
   end

   // FSM next state: on the final bit, stay in SHIFT only if another value is queued
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (bus.bin_valid_i) state_d = SHIFT;
         SHIFT:   if (last && !bus.bin_valid_i && !pend_q) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // FSM outputs
   always_comb begin
      busy = (state_q == SHIFT);
   end

   // Datapath: shift register, bit counter, pending slot and result registers
   always_ff @(posedge clk) begin
      if (reset) begin
         sreg_q     <= '0;
         cnt_q      <= '0;
         ovf_q      <= 1'b0;
         pend_q     <= 1'b0;
         pend_val_q <= '0;
         bcd_q      <= '0;
         en_q       <= D'(1);
         ovf_out_q  <= 1'b0;
         valid_q    <= 1'b0;
      end else begin
         valid_q <= last;
         if (load) begin
            sreg_q <= {{(4*D){1'b0}}, load_val};
            cnt_q  <= '0;
            ovf_q  <= load_ovf;
            pend_q <= 1'b0;
         end else if (state_q == SHIFT) begin
            sreg_q <= shifted;
            cnt_q  <= cnt_q + CW'(1);
         end
         // A strobe during a running conversion is parked; the latest value wins
         if ((state_q == SHIFT) && !last && bus.bin_valid_i) begin
            pend_q     <= 1'b1;
            pend_val_q <= bus.bin_i;
         end
         if (last) begin
            if (ovf_q) begin
               bcd_q     <= {D{4'h9}};
               en_q      <= '1;
               ovf_out_q <= 1'b1;
            end else begin
               bcd_q     <= digits;
               en_q      <= en_calc;
               ovf_out_q <= 1'b0;
            end
         end
      end
   end

   assign bus.busy_o      = busy;
   assign bus.bcd_o       = bcd_q;
   assign bus.digit_en_o  = en_q;
   assign bus.overflow_o  = ovf_out_q;
   assign bus.bcd_valid_o = valid_q;
endmodule
